ant_step_sequencer: RTL and testbench

//  Paces the ant navigation FSM and handles its move handshake with the maze/world model.

---
 rtl/ant_pkg.sv | 41 ++++
 rtl/ant_tick_div.sv | 45 ++++
 rtl/ant_step_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ant_step_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ant_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ant_pkg
//  Purpose  : Shared definitions for the ant step sequencer. Holds the ant
//             navigation FSM state codes, the sequencer state encoding, the
//             bit positions of the move command, and the lost-counter helper.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package ant_pkg;

   // Ant navigation FSM state codes, as reported on antState.
   localparam logic [1:0] c_ANT_A    = 2'b00;
   localparam logic [1:0] c_ANT_B    = 2'b01;
   localparam logic [1:0] c_ANT_E    = 2'b10;
   localparam logic [1:0] c_ANT_LOST = 2'b11;

   // Sequencer state encoding.
   localparam int         c_SEQ_W      = 3;
   localparam logic [2:0] c_SEQ_IDLE   = 3'd0;
   localparam logic [2:0] c_SEQ_WAIT   = 3'd1;
   localparam logic [2:0] c_SEQ_SAMPLE = 3'd2;
   localparam logic [2:0] c_SEQ_STEP   = 3'd3;
   localparam logic [2:0] c_SEQ_CMD    = 3'd4;
   localparam logic [2:0] c_SEQ_HS     = 3'd5;

   // Bit positions inside move_cmd.
   localparam int c_CMD_FW     = 2;
   localparam int c_CMD_TLEFT  = 1;
   localparam int c_CMD_TRIGHT = 0;

   // Width of the consecutive-Lost counter (LOST_LIMIT is at most 255).
   localparam int c_LOST_W = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [c_LOST_W-1:0] satIncLost(input logic [c_LOST_W-1:0] v);
      return (v == {c_LOST_W{1'b1}}) ? v : v + c_LOST_W'(1);
   endfunction

endpackage : ant_pkg
`default_nettype wire

// File: rtl/ant_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : ant_tick_div
//  Purpose  : Step-rate prescaler. Counts 0..TICK_DIV-1 while enabled and
//             pulses o_terminal on the last count, wrapping back to 0.
//  Ports    : CLK        in  system clock
//             reset      in  asynchronous reset, active low
//             i_clear    in  synchronous clear of the count (wins over enable)
//             i_enable   in  advance the count this cycle
//             o_terminal out high on the cycle holding the terminal count
//  Revision : 1.0  initial release
// ============================================================================
module ant_tick_div #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic CLK,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int              c_CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

   logic [c_CW-1:0] r_count;
   logic            w_atLast;

   assign w_atLast = (r_count == c_LAST);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_atLast ? '0 : r_count + c_CW'(1);
      end
   end

   // Terminal only counts when the count actually advances this cycle.
   assign o_terminal = i_enable && !i_clear && w_atLast;

endmodule : ant_tick_div
`default_nettype wire

// File: rtl/ant_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ant_step_sequencer
//  Purpose  : Paces the ant navigation FSM and runs its move handshake with
//             the maze model. One step = tick -> latch antennas -> one-cycle
//             ant_tick -> capture {FW,TLeft,TRight} -> req/ack with maze.
//             Free-run (run) and single-step (step_btn) operation; flags a
//             stuck ant after LOST_LIMIT consecutive steps in the Lost state.
//  Ports    : CLK          in   system clock
//             reset        in   asynchronous reset, active low
//             run          in   free-run enable (level)
//             step_btn     in   single-step request pulse (honoured in IDLE)
//             clr          in   clear move_count, lost counter and stuck
//             LAntenna_in  in   raw left antenna
//             RAntenna_in  in   raw right antenna
//             FW/TLeft/TRight in command outputs of the ant FSM
//             antState     in   ant FSM state code
//             LAnt_q       out  latched left antenna
//             RAnt_q       out  latched right antenna
//             ant_tick     out  one-cycle step strobe for the ant FSM
//             move_req     out  move request to maze model
//             move_cmd     out  {FW,TLeft,TRight}, stable while move_req
//             move_ack     in   maze model accepted move_cmd
//             move_count   out  completed moves, saturating
//             stuck        out  sticky stuck-ant flag
//  Revision : 1.0  initial release
// ============================================================================
module ant_step_sequencer
   import ant_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int LOST_LIMIT = 16,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             run,
   input  logic             step_btn,
   input  logic             clr,
   input  logic             LAntenna_in,
   input  logic             RAntenna_in,
   input  logic             FW,
   input  logic             TLeft,
   input  logic             TRight,
   input  logic [1:0]       antState,
   output logic             LAnt_q,
   output logic             RAnt_q,
   output logic             ant_tick,
   output logic             move_req,
   output logic [2:0]       move_cmd,
   input  logic             move_ack,
   output logic [CNT_W-1:0] move_count,
   output logic             stuck
);

   localparam logic [c_LOST_W-1:0] c_LOST_LIMIT = c_LOST_W'(LOST_LIMIT);

   logic [c_SEQ_W-1:0]  r_state;
   logic [c_SEQ_W-1:0]  w_nextState;
   logic                w_tickEnable;
   logic                w_tickClear;
   logic                w_terminal;
   logic                w_ackDone;
   logic [2:0]          w_cmdIn;
   logic [c_LOST_W-1:0] r_lostCnt;
   logic [c_LOST_W-1:0] w_lostNext;

   // ------------------------------------------------------------------------
   // Prescaler: only runs while waiting in free-run; held at 0 otherwise so
   // every WAIT visit starts a full TICK_DIV period.
   // ------------------------------------------------------------------------
   ant_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tickDiv (
      .CLK        (CLK),
      .reset      (reset),
      .i_clear    (w_tickClear),
      .i_enable   (w_tickEnable),
      .o_terminal (w_terminal)
   );

   // ------------------------------------------------------------------------
   // State register. Asynchronous reset returns to IDLE at once, which also
   // drops move_req immediately because move_req is decoded from state.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state <= c_SEQ_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic.
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_SEQ_IDLE: begin
            // A stuck ant parks here until clr; run has priority over step_btn.
            if (!stuck) begin
               if (run) begin
                  w_nextState = c_SEQ_WAIT;
               end else if (step_btn) begin
                  w_nextState = c_SEQ_SAMPLE;
               end
            end
         end
         c_SEQ_WAIT: begin
            if (!run) begin
               w_nextState = c_SEQ_IDLE;
            end else if (w_terminal) begin
               w_nextState = c_SEQ_SAMPLE;
            end
         end
         c_SEQ_SAMPLE: w_nextState = c_SEQ_STEP;
         c_SEQ_STEP:   w_nextState = c_SEQ_CMD;
         c_SEQ_CMD:    w_nextState = c_SEQ_HS;
         c_SEQ_HS: begin
            // stuck was registered on the CMD cycle, so it is already visible
            // here and the ant parks once this handshake finishes.
            if (move_ack) begin
               w_nextState = (run && !stuck) ? c_SEQ_WAIT : c_SEQ_IDLE;
            end
         end
         default: w_nextState = c_SEQ_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs decoded from state.
   // ------------------------------------------------------------------------
   always_comb begin
      ant_tick     = (r_state == c_SEQ_STEP);
      move_req     = (r_state == c_SEQ_HS);
      w_tickEnable = (r_state == c_SEQ_WAIT) && run;
      w_tickClear  = !w_tickEnable;
      w_ackDone    = (r_state == c_SEQ_HS) && move_ack;
   end

   // ------------------------------------------------------------------------
   // Command assembly and lost-counter next value.
   // ------------------------------------------------------------------------
   always_comb begin
      w_cmdIn               = '0;
      w_cmdIn[c_CMD_FW]     = FW;
      w_cmdIn[c_CMD_TLEFT]  = TLeft;
      w_cmdIn[c_CMD_TRIGHT] = TRight;
      w_lostNext = (antState == c_ANT_LOST) ? satIncLost(r_lostCnt) : '0;
   end

   // ------------------------------------------------------------------------
   // Antenna latch and command capture. move_cmd only changes in CMD, so it
   // is inherently stable for the whole HS wait.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         LAnt_q   <= 1'b0;
         RAnt_q   <= 1'b0;
         move_cmd <= '0;
      end else begin
         if (r_state == c_SEQ_SAMPLE) begin
            LAnt_q <= LAntenna_in;
            RAnt_q <= RAntenna_in;
         end
         if (r_state == c_SEQ_CMD) begin
            move_cmd <= w_cmdIn;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Move counter, lost counter and stuck flag. clr overrides any update in
   // the same cycle, including the ack increment.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         move_count <= '0;
         r_lostCnt  <= '0;
         stuck      <= 1'b0;
      end else if (clr) begin
         move_count <= '0;
         r_lostCnt  <= '0;
         stuck      <= 1'b0;
      end else begin
         if (w_ackDone && (move_count != {CNT_W{1'b1}})) begin
            move_count <= move_count + CNT_W'(1);
         end
         if (r_state == c_SEQ_CMD) begin
            r_lostCnt <= w_lostNext;
            if (w_lostNext >= c_LOST_LIMIT) begin
               stuck <= 1'b1;
            end
         end
      end
   end

endmodule : ant_step_sequencer
`default_nettype wire

// File: tb/tb_ant_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ant_step_sequencer
//  Purpose  : Self-checking bench for ant_step_sequencer. A driver issues
//             steps and pushes the expected outcome of each into a queue; a
//             monitor pops and compares whenever the DUT raises move_req.
//  Ports    : (testbench, none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_ant_step_sequencer;

   localparam int TICK_DIV   = 4;
   localparam int LOST_LIMIT = 3;
   localparam int CNT_W      = 2;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             reset = 1'b0;
   logic             run = 1'b0;
   logic             step_btn = 1'b0;
   logic             clr = 1'b0;
   logic             LAntenna_in = 1'b0;
   logic             RAntenna_in = 1'b0;
   logic             FW = 1'b0;
   logic             TLeft = 1'b0;
   logic             TRight = 1'b0;
   logic [1:0]       antState = 2'b00;
   logic             move_ack = 1'b0;
   logic             LAnt_q;
   logic             RAnt_q;
   logic             ant_tick;
   logic             move_req;
   logic [2:0]       move_cmd;
   logic [CNT_W-1:0] move_count;
   logic             stuck;

   always #5 CLK = ~CLK;

   ant_step_sequencer #(
      .TICK_DIV   (TICK_DIV),
      .LOST_LIMIT (LOST_LIMIT),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .run         (run),
      .step_btn    (step_btn),
      .clr         (clr),
      .LAntenna_in (LAntenna_in),
      .RAntenna_in (RAntenna_in),
      .FW          (FW),
      .TLeft       (TLeft),
      .TRight      (TRight),
      .antState    (antState),
      .LAnt_q      (LAnt_q),
      .RAnt_q      (RAnt_q),
      .ant_tick    (ant_tick),
      .move_req    (move_req),
      .move_cmd    (move_cmd),
      .move_ack    (move_ack),
      .move_count  (move_count),
      .stuck       (stuck)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic abortRun(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no move_req expected move_req within bound", name);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // --------------------------------------------------------------------
   // Reference model: step outcomes from the rules, plain integers.
   // --------------------------------------------------------------------
   typedef struct {
      logic [2:0] cmd;
      logic       la;
      logic       ra;
      int         cnt;
      bit         stk;
   } exp_t;

   exp_t expQ[$];
   int   mCnt   = 0;
   int   mLost  = 0;
   bit   mStuck = 1'b0;

   // --------------------------------------------------------------------
   // Monitor: samples 7 ns after each rising edge.
   // --------------------------------------------------------------------
   exp_t cur;
   bit   prevReq     = 1'b0;
   bit   pendPost    = 1'b0;
   int   cyc         = 0;
   int   tickCyc     = -100;
   int   tickCnt     = 0;
   int   lastSpacing = 0;

   always @(posedge CLK) begin
      #7;
      cyc++;
      if (!reset) begin
         expQ.delete();
         prevReq  = 1'b0;
         pendPost = 1'b0;
         tickCnt  = 0;
         tickCyc  = -100;
      end else begin
         if (pendPost) begin
            check("count_after_ack", 32'(move_count), cur.cnt);
            check("stuck_after_ack", 32'(stuck), 32'(cur.stk));
            pendPost = 1'b0;
         end
         if (ant_tick) begin
            if (tickCyc >= 0) lastSpacing = cyc - tickCyc;
            tickCyc = cyc;
            tickCnt++;
         end
         if (move_req && !prevReq) begin
            check("tick_pulses_per_step", tickCnt, 1);
            check("tick_to_req_latency", cyc - tickCyc, 2);
            tickCnt = 0;
            check("req_expected", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
               cur = expQ.pop_front();
               check("move_cmd", 32'(move_cmd), 32'(cur.cmd));
               check("LAnt_q", 32'(LAnt_q), 32'(cur.la));
               check("RAnt_q", 32'(RAnt_q), 32'(cur.ra));
            end
         end else if (move_req) begin
            check("move_cmd_stable", 32'(move_cmd), 32'(cur.cmd));
         end
         if (move_req && move_ack) pendPost = 1'b1;
         prevReq = move_req;
      end
   end

   // --------------------------------------------------------------------
   // Driver: acts 2 ns after each rising edge.
   // --------------------------------------------------------------------
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic doClr();
      clr = 1'b1;
      tick();
      clr    = 1'b0;
      mCnt   = 0;
      mLost  = 0;
      mStuck = 1'b0;
   endtask

   task automatic checkZero(input string tag);
      check({tag, "_LAnt_q"},     32'(LAnt_q),     0);
      check({tag, "_RAnt_q"},     32'(RAnt_q),     0);
      check({tag, "_ant_tick"},   32'(ant_tick),   0);
      check({tag, "_move_req"},   32'(move_req),   0);
      check({tag, "_move_cmd"},   32'(move_cmd),   0);
      check({tag, "_move_count"}, 32'(move_count), 0);
      check({tag, "_stuck"},      32'(stuck),      0);
   endtask

   task automatic doStep(input bit useRun, input int ackDly, input bit clrAck, input bit dropRun,
                         input bit rstHs, input logic [2:0] cmd, input logic [1:0] st,
                         input logic la, input logic ra);
      exp_t e;
      int   nLost;
      bit   nStuck;
      int   nCnt;
      int   n;
      if (mStuck) doClr();
      LAntenna_in         = la;
      RAntenna_in         = ra;
      {FW, TLeft, TRight} = cmd;
      antState            = st;
      nLost  = (st == 2'b11) ? ((mLost < 255) ? mLost + 1 : 255) : 0;
      nStuck = mStuck || (nLost >= LOST_LIMIT);
      nCnt   = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
      if (clrAck) begin
         nLost  = 0;
         nStuck = 1'b0;
         nCnt   = 0;
      end
      e.cmd = cmd; e.la = la; e.ra = ra; e.cnt = nCnt; e.stk = nStuck;
      expQ.push_back(e);
      if (useRun) begin
         run = 1'b1;
      end else begin
         step_btn = 1'b1;
         tick();
         step_btn = 1'b0;
      end
      // Stray acks and (in run mode) stray step pulses before HS must be ignored.
      n = 0;
      while (!move_req) begin
         move_ack = ($urandom_range(0, 3) == 0);
         step_btn = run && ($urandom_range(0, 3) == 0);
         tick();
         n++;
         if (n > 4 * TICK_DIV + 20) abortRun("req_timeout");
      end
      move_ack = 1'b0;
      step_btn = 1'b0;
      if (rstHs) begin
         tick();
         reset = 1'b0;
         #1;
         check("req_drop_on_reset", 32'(move_req), 0);
         tick();
         tick();
         run    = 1'b0;
         reset  = 1'b1;
         mCnt   = 0;
         mLost  = 0;
         mStuck = 1'b0;
         return;
      end
      repeat (ackDly) tick();
      move_ack = 1'b1;
      clr      = clrAck;
      if (dropRun) run = 1'b0;
      tick();
      move_ack = 1'b0;
      clr      = 1'b0;
      mCnt   = nCnt;
      mLost  = nLost;
      mStuck = nStuck;
   endtask

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int         act;
      bit         ur;
      int         k;
      logic [1:0] st;

      repeat (3) tick();
      reset = 1'b1;
      tick();
      checkZero("reset");

      // Single step, ack two cycles into HS.
      doStep(1'b0, 2, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 1'b1, 1'b0);
      check("count_single", 32'(move_count), 1);
      act = 0;
      repeat (10) begin
         act += int'(move_req | ant_tick);
         tick();
      end
      check("idle_after_single", act, 0);

      // Free run, ack in the first HS cycle: steps every TICK_DIV+4 cycles.
      doClr();
      doStep(1'b1, 0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 1'b0, 1'b0);
      doStep(1'b1, 0, 1'b0, 1'b0, 1'b0, 3'b010, 2'b01, 1'b1, 1'b0);
      check("tick_spacing_2", lastSpacing, TICK_DIV + 4);
      doStep(1'b1, 0, 1'b0, 1'b1, 1'b0, 3'b001, 2'b10, 1'b0, 1'b1);
      check("tick_spacing_3", lastSpacing, TICK_DIV + 4);
      check("count_run", 32'(move_count), 3);

      // Command capture with a long ack wait.
      doStep(1'b0, 10, 1'b0, 1'b0, 1'b0, 3'b110, 2'b00, 1'b0, 1'b1);

      // Stuck after LOST_LIMIT Lost steps; run ignored until clr.
      doClr();
      repeat (LOST_LIMIT) doStep(1'b0, 1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0, 1'b0);
      check("stuck_set", 32'(stuck), 1);
      run = 1'b1;
      act = 0;
      repeat (20) begin
         act += int'(move_req | ant_tick);
         tick();
      end
      check("stuck_holds_idle", act, 0);
      doClr();
      check("stuck_cleared", 32'(stuck), 0);
      doStep(1'b1, 0, 1'b0, 1'b1, 1'b0, 3'b100, 2'b00, 1'b1, 1'b1);

      // clr coinciding with ack wins.
      doStep(1'b0, 1, 1'b1, 1'b0, 1'b0, 3'b010, 2'b01, 1'b1, 1'b0);
      check("clr_on_ack", 32'(move_count), 0);

      // Saturation at all-ones.
      repeat (5) doStep(1'b0, 0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 1'b0, 1'b0);
      check("count_saturated", 32'(move_count), CNT_MAX);

      // Reset during HS.
      doStep(1'b0, 0, 1'b0, 1'b0, 1'b1, 3'b101, 2'b01, 1'b1, 1'b1);
      checkZero("reset_mid_hs");

      // Randomised chunks of free-run and single steps.
      for (int c = 0; c < 14; c++) begin
         ur = 1'($urandom_range(0, 1));
         k  = $urandom_range(1, 4);
         for (int i = 0; i < k; i++) begin
            st = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 2));
            doStep(ur, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), ur && (i == k - 1), 1'b0,
                   3'($urandom_range(0, 7)), st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ant_step_sequencer
`default_nettype wire
